// File: rtl/addsub_sequencer.sv
// Two-requester add/subtract unit with round-robin arbitration.
// Operands are summed through one 4-bit ripple slice over four cycles.
module addsub_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] A0,
  input  logic [15:0] B0,
  input  logic [15:0] A1,
  input  logic [15:0] B1,
  input  logic        sub0,
  input  logic        sub1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] S,
  output logic        Co,
  output logic        V
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] acc;
  logic [1:0]  nib;
  logic        carry;
  logic        id_r;
  logic        last_id;

  logic        accept;
  logic        win_id;
  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  sum;
  logic [15:0] acc_nx;
  logic        c15;

  assign accept = (state != RUN) && (req != 2'b00);

  // On a tie the requester not served last wins.
  assign win_id = req[1] & (~req[0] | ~last_id);

  always_comb begin
    a_nib  = a_r[{nib, 2'b00} +: 4];
    b_nib  = b_r[{nib, 2'b00} +: 4];
    sum    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
    acc_nx = acc;
    acc_nx[{nib, 2'b00} +: 4] = sum[3:0];
    c15    = sum[3] ^ a_nib[3] ^ b_nib[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      nib     <= '0;
      carry   <= 1'b0;
      id_r    <= 1'b0;
      last_id <= 1'b1;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      S       <= '0;
      Co      <= 1'b0;
      V       <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_r     <= win_id ? A1 : A0;
            b_r     <= win_id ? (sub1 ? ~B1 : B1)
                              : (sub0 ? ~B0 : B0);
            carry   <= win_id ? sub1 : sub0;
            nib     <= '0;
            id_r    <= win_id;
            last_id <= win_id;
            gnt     <= win_id ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          carry <= sum[4];
          nib   <= nib + 2'd1;
          if (nib == 2'd3) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            S       <= acc_nx;
            Co      <= sum[4];
            V       <= sum[4] ^ c15;
            done_id <= id_r;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_addsub_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] A0, B0, A1, B1;
  logic        sub0, sub1;
  logic [1:0]  gnt;
  logic        busy, done, done_id;
  logic [15:0] S;
  logic        Co, V;

  int          n_vec;
  int          n_bad;
  logic [15:0] last_s;

  addsub_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .A0      (A0),
    .B0      (B0),
    .A1      (A1),
    .B1      (B1),
    .sub0    (sub0),
    .sub1    (sub1),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .S       (S),
    .Co      (Co),
    .V       (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; leaves the bench on a falling edge in IDLE.
  task automatic do_op(input logic        id,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic        sb,
                       input logic        scramble,
                       input logic [15:0] exp_s,
                       input logic        exp_co,
                       input logic        exp_v);
    if (id == 1'b0) begin
      A0 = a; B0 = b; sub0 = sb; req = 2'b01;
    end else begin
      A1 = a; B1 = b; sub1 = sb; req = 2'b10;
    end
    @(negedge clk);
    chk("gnt", {30'b0, gnt}, id ? 32'd2 : 32'd1);
    chk("busy_c1", {31'b0, busy}, 32'd1);
    chk("done_c1", {31'b0, done}, 32'd0);
    chk("s_hold_c1", {16'b0, S}, {16'b0, last_s});
    req = 2'b00;
    if (scramble) begin
      if (id == 1'b0) begin
        A0 = ~a; B0 = ~b; sub0 = ~sb;
      end else begin
        A1 = ~a; B1 = ~b; sub1 = ~sb;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_run", {31'b0, busy}, 32'd1);
      chk("gnt_run", {30'b0, gnt}, 32'd0);
      chk("done_run", {31'b0, done}, 32'd0);
      chk("s_hold_run", {16'b0, S}, {16'b0, last_s});
    end
    @(negedge clk);
    chk("done", {31'b0, done}, 32'd1);
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("S", {16'b0, S}, {16'b0, exp_s});
    chk("Co", {31'b0, Co}, {31'b0, exp_co});
    chk("V", {31'b0, V}, {31'b0, exp_v});
    chk("done_id", {31'b0, done_id}, {31'b0, id});
    last_s = exp_s;
    @(negedge clk);
    chk("done_clr", {31'b0, done}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("s_keep", {16'b0, S}, {16'b0, last_s});
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    last_s = 16'h0;
    rst_n  = 1'b0;
    req    = 2'b11;
    A0 = 16'd1;  B0 = 16'd2; sub0 = 1'b0;
    A1 = 16'd10; B1 = 16'd3; sub1 = 1'b1;
    #2;
    chk("rst_gnt", {30'b0, gnt}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_S", {16'b0, S}, 32'd0);
    chk("rst_CoV", {30'b0, Co, V}, 32'd0);
    chk("rst_id", {31'b0, done_id}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contending requests held from reset: grants alternate, no gap.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt", {30'b0, gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("rr_busy", {31'b0, busy}, 32'd1);
      end
      @(negedge clk);
      chk("rr_done", {31'b0, done}, 32'd1);
      chk("rr_id", {31'b0, done_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_S", {16'b0, S}, (k % 2 == 0) ? 32'd3 : 32'd7);
      chk("rr_Co", {31'b0, Co}, (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k == 3) req = 2'b00;
    end
    last_s = 16'd7;
    @(negedge clk);
    chk("rr_idle_busy", {31'b0, busy}, 32'd0);
    chk("rr_idle_gnt", {30'b0, gnt}, 32'd0);

    do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    do_op(1'b0, 16'h0100, 16'h0023, 1'b1, 1'b1, 16'h00DD, 1'b1, 1'b0);

    // Reset during the third RUN cycle aborts the operation.
    A0 = 16'h1111; B0 = 16'h2222; sub0 = 1'b0; req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ab_gnt", {30'b0, gnt}, 32'd0);
    chk("ab_busy", {31'b0, busy}, 32'd0);
    chk("ab_done", {31'b0, done}, 32'd0);
    chk("ab_S", {16'b0, S}, 32'd0);
    chk("ab_CoV", {30'b0, Co, V}, 32'd0);
    chk("ab_id", {31'b0, done_id}, 32'd0);
    @(negedge clk);
    chk("ab_no_done", {31'b0, done}, 32'd0);
    rst_n  = 1'b1;
    last_s = 16'h0;
    @(negedge clk);
    chk("ab_idle_done", {31'b0, done}, 32'd0);
    chk("ab_idle_busy", {31'b0, busy}, 32'd0);
    do_op(1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_sequencer.md
ADDSUB_SEQUENCER -- requirements
Module: addsub_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req, input, 2 bits: request from requester 0 (bit 0) and requester 1 (bit 1); level, held until granted.
REQ-004 SHALL have ports A0, B0, input, 16 bits each: operands of requester 0.
REQ-005 SHALL have ports A1, B1, input, 16 bits each: operands of requester 1.
REQ-006 SHALL have ports sub0, sub1, input, 1 bit each: per-requester operation select; 0 = A+B, 1 = A-B.
REQ-007 SHALL have port gnt, output, 2 bits: one-hot grant pulse, one cycle, to the accepted requester.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in RUN.
REQ-009 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 SHALL have port done_id, output, 1 bit: index of the requester owning the current result.
REQ-011 SHALL have port S, output, 16 bits: result (sum or difference).
REQ-012 SHALL have port Co, output, 1 bit: carry out; for subtraction 1 = no borrow.
REQ-013 SHALL have port V, output, 1 bit: two's-complement overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; the datapath SHALL be a single 4-bit ripple adder slice reused across 4 cycles (nibble-serial).
REQ-015 SHALL accept a request at a rising edge when the state is IDLE or DONE and req != 0 (acceptance edge E0); otherwise req SHALL be ignored without being lost (requester keeps it held).
REQ-016 At E0 it SHALL latch A and B of the winner, invert B if sub, set internal carry = sub, clear nibble index to 0, record winner id, go to RUN.
REQ-017 Arbitration SHALL be round-robin: on simultaneous req = 2'b11 the requester not granted last wins; the last-granted pointer SHALL reset to 1 (requester 0 wins first).
REQ-018 gnt SHALL be high exactly during the cycle following E0, one-hot to the winner.
REQ-019 In RUN each edge E1..E4 SHALL add nibble n of A, modified B and internal carry, write sum nibble n of an internal accumulator, update carry, increment n; at E4 (n = 3) it SHALL go to DONE.
REQ-020 At E4 it SHALL load S from the accumulator, Co from the final carry, V = carry into bit 15 XOR carry out of bit 15, and done_id from the recorded id.
REQ-021 done SHALL be high exactly the one cycle in DONE (the 5th cycle after E0); throughput SHALL be one operation per 5 cycles under back-to-back requests.
REQ-022 S, Co, V, done_id SHALL hold their values until the next E4; they SHALL NOT change during a following RUN.
REQ-023 busy SHALL be high exactly in RUN (4 cycles per operation), low in IDLE and DONE.
REQ-024 DONE with no pending request SHALL go to IDLE at the next edge.
REQ-025 Operand or sub changes after E0 SHALL not affect the operation in flight.
REQ-026 Arithmetic SHALL be modulo 2^16; no saturation.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, gnt = 0, busy = 0, done = 0, done_id = 0, S = 0, Co = 0, V = 0, nibble index 0, internal carry 0, round-robin pointer 1.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no done SHALL follow for it; after rst_n rises the first acceptance edge SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-029 req=01, A0=0x1234, B0=0x0FFF, sub0=0 -> gnt=01 one cycle, busy 4 cycles, done pulse 5th cycle: S=0x2233, Co=0, V=0, done_id=0.
REQ-030 req=10, A1=0x8000, B1=0x0001, sub1=1 -> S=0x7FFF, Co=1, V=1, done_id=1; then A0=0x7FFF+B0=0x0001 -> S=0x8000, Co=0, V=1.
REQ-031 req=01, A0=0xFFFF, B0=0x0001, sub0=0 -> S=0x0000, Co=1, V=0; and A0=0x0000-B0=0x0001 -> S=0xFFFF, Co=0, V=0.
REQ-032 req=11 held continuously from reset -> grants alternate 01,10,01,10 on consecutive operations, each done 5 cycles after its acceptance edge, no idle cycle between done and next gnt.
REQ-033 Start an operation, pull rst_n low during 3rd RUN cycle -> all outputs 0 immediately, no done; after release, a new req=01 completes with correct result and gnt=01.
REQ-034 Change A0/B0/sub0 during RUN -> result reflects values latched at E0; S from previous operation stable until the new done.
